// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Brief    : Bitwise logic unit with XOR accumulator and one registered output
//            stage under valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             parity
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_XOR  = 3'b010;
    localparam logic [2:0] c_OP_XNOR = 3'b011;
    localparam logic [2:0] c_OP_NAND = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_NOT  = 3'b110;
    localparam logic [2:0] c_OP_ACCX = 3'b111;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_parity;
    logic [WIDTH-1:0] r_acc;

    logic             w_in_ready;
    logic             w_in_xfer;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_result;

    // Ready is forced high while in reset so upstream never sees a stall there.
    assign w_in_ready = !rst_n || !r_out_valid || out_ready;
    assign w_in_xfer  = in_valid && w_in_ready;

    // A coincident clear is applied before accumulating.
    assign w_acc_base = acc_clr ? '0 : r_acc;

    always_comb begin
        w_result = '0;
        case (op)
            c_OP_AND:  w_result = in1 & in2;
            c_OP_OR:   w_result = in1 | in2;
            c_OP_XOR:  w_result = in1 ^ in2;
            c_OP_XNOR: w_result = ~(in1 ^ in2);
            c_OP_NAND: w_result = ~(in1 & in2);
            c_OP_NOR:  w_result = ~(in1 | in2);
            c_OP_NOT:  w_result = ~in1;
            c_OP_ACCX: w_result = w_acc_base ^ in1 ^ in2;
            default:   w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_zero      <= 1'b0;
            r_parity    <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out       <= w_result;
            r_zero      <= (w_result == '0);
            r_parity    <= ^w_result;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_in_xfer && (op == c_OP_ACCX)) begin
            r_acc <= w_result;
        end else begin
            r_acc <= w_acc_base;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign zero      = r_zero;
    assign parity    = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Brief    : Scoreboard bench for logic_unit_pipe: directed cases plus random
//            traffic against a reference model of the operation table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [2:0]   op;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zero;
    logic         parity;

    logic [W-1:0] exp_q[$];
    logic         m_valid;
    logic [W-1:0] m_acc;
    int           n_checks = 0;
    int           n_pass   = 0;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .parity    (parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] acc);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (o)
                3'd0: r[i] = a[i] && b[i];
                3'd1: r[i] = a[i] || b[i];
                3'd2: r[i] = a[i] != b[i];
                3'd3: r[i] = a[i] == b[i];
                3'd4: r[i] = !(a[i] && b[i]);
                3'd5: r[i] = !(a[i] || b[i]);
                3'd6: r[i] = !a[i];
                default: r[i] = (acc[i] + a[i] + b[i]) % 2 == 1;
            endcase
        end
        return r;
    endfunction

    // Entered one time unit after a rising edge; leaves at the same point of the next cycle.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] o, input logic clr, input logic ordy, input logic rn);
        logic         rdy;
        logic [W-1:0] base;
        logic [W-1:0] res;
        rst_n = rn; in_valid = v; in1 = a; in2 = b; op = o; acc_clr = clr; out_ready = ordy;
        #1;
        if (!rn) begin
            chk("in_ready_in_reset", 64'(in_ready), 64'd1);
            exp_q.delete();
            m_valid = 1'b0;
            m_acc   = '0;
        end else begin
            rdy = !m_valid || ordy;
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("in_ready", 64'(in_ready), 64'(rdy));
            base = clr ? '0 : m_acc;
            if (v && rdy) begin
                res = ref_op(o, a, b, base);
                exp_q.push_back(res);
                m_acc   = (o == 3'd7) ? res : base;
                m_valid = 1'b1;
            end else begin
                m_acc = base;
                if (ordy) m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents with the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(out), 64'hDEAD);
            end else begin
                chk("out", 64'(out), 64'(exp_q[0]));
                chk("zero", 64'(zero), 64'(exp_q[0] == '0));
                chk("parity", 64'(parity), 64'(^exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        m_valid = 1'b0;
        m_acc   = '0;
        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; op = '0; acc_clr = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 4'hF, 4'hF, 3'd2, 1'b0, 1'b0, 1'b0);
        chk("reset_out", 64'(out), 64'd0);
        chk("reset_zero", 64'(zero), 64'd0);
        chk("reset_parity", 64'(parity), 64'd0);

        // XOR basic, then AND held under backpressure with a competing op waiting
        cycle(1'b1, 4'b1010, 4'b0110, 3'd2, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b1010, 4'b0101, 3'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'b1111, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'b1111, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'b1111, 4'b0000, 3'd1, 1'b0, 1'b1, 1'b1);

        // Back-to-back accumulation, then clear coinciding with ACCX
        cycle(1'b1, 4'b0001, 4'b0010, 3'd7, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 4'b0100, 4'b0000, 3'd7, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b1000, 4'b1111, 3'd7, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b0111, 4'b0000, 3'd7, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b0011, 4'b0001, 3'd7, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 4'b0000, 4'b0000, 3'd7, 1'b0, 1'b1, 1'b1);

        // Clear while idle, then NOT/NAND boundary values
        cycle(1'b0, 4'b1111, 4'b1111, 3'd7, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 4'b0000, 4'b0000, 3'd7, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 4'b1111, 3'd4, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b0011, 4'b0000, 3'd6, 1'b0, 1'b1, 1'b1);

        // Reset with a stalled result and acc=1111, then accumulate from zero
        cycle(1'b1, 4'b1111, 4'b0000, 3'd7, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'b0101, 4'b0101, 3'd1, 1'b0, 1'b0, 1'b0);
        chk("post_reset_out", 64'(out), 64'd0);
        cycle(1'b1, 4'b0001, 4'b0000, 3'd7, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, W'($urandom), W'($urandom), 3'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) != 0);
        end

        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
